// File: rtl/bepu_bus_arbiter_if.sv
// bepu_bus_arbiter_if: two master request/ack channels plus the peripheral bus; slave = arbiter side, master = initiator/back-end side
interface bepu_bus_arbiter_if;
  logic        m0_req, m0_w, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_w, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] bus_select, bus_addr, bus_wdata, bus_rdata;
  logic        bus_w, busy;
  modport slave (
    input  m0_req, m0_w, m0_addr, m0_wdata, m1_req, m1_w, m1_addr, m1_wdata, bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata, bus_select, bus_w, bus_addr, bus_wdata, busy
  );
  modport master (
    output m0_req, m0_w, m0_addr, m0_wdata, m1_req, m1_w, m1_addr, m1_wdata, bus_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata, bus_select, bus_w, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/bepu_bus_arbiter.sv
// bepu_bus_arbiter: 2-master arbiter/sequencer (clk, rst, b: m0/m1 req-w-addr-wdata in, ack-rdata out; bus select/w/addr/wdata out, bus_rdata in, busy out)
module bepu_bus_arbiter #(
  parameter bit RR_ENABLE  = 1'b1,
  parameter int REGION_LSB = 12
) (
  input logic clk,
  input logic rst,
  bepu_bus_arbiter_if.slave b
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last, win, lw, gnt;
  logic [31:0] g_addr, rd;
  function automatic logic [31:0] decode(input logic [3:0] r);
    return r == 4'd0 ? 32'h8000_0000 : r <= 4'd4 ? 32'd1 << (r - 4'd1) : 32'd0;
  endfunction
  always_comb begin
    gnt = (b.m0_req && b.m1_req) ? (RR_ENABLE ? ~last : 1'b0) : b.m1_req;
    g_addr = gnt ? b.m1_addr : b.m0_addr;
    rd = (lw || b.bus_select == '0) ? '0 : b.bus_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      win          <= 1'b0;
      lw           <= 1'b0;
      b.m0_ack     <= 1'b0;
      b.m1_ack     <= 1'b0;
      b.m0_rdata   <= '0;
      b.m1_rdata   <= '0;
      b.bus_select <= '0;
      b.bus_w      <= 1'b0;
      b.bus_addr   <= '0;
      b.bus_wdata  <= '0;
      b.busy       <= 1'b0;
    end else begin
      b.m0_ack <= 1'b0;
      b.m1_ack <= 1'b0;
      case (state)
        IDLE: if (b.m0_req || b.m1_req) begin
          win          <= gnt;
          last         <= gnt;
          lw           <= gnt ? b.m1_w : b.m0_w;
          b.bus_w      <= gnt ? b.m1_w : b.m0_w;
          b.bus_addr   <= g_addr;
          b.bus_wdata  <= gnt ? b.m1_wdata : b.m0_wdata;
          b.bus_select <= decode(g_addr[REGION_LSB+3:REGION_LSB]);
          b.busy       <= 1'b1;
          state        <= ACCESS;
        end
        ACCESS: begin
          b.bus_w <= 1'b0;
          state   <= RESP;
        end
        default: begin
          if (win) begin
            b.m1_rdata <= rd;
            b.m1_ack   <= 1'b1;
          end else begin
            b.m0_rdata <= rd;
            b.m0_ack   <= 1'b1;
          end
          b.bus_select <= '0;
          b.bus_addr   <= '0;
          b.bus_wdata  <= '0;
          b.busy       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bepu_bus_arbiter.sv
// tb_bepu_bus_arbiter: round-robin and fixed-priority arbiters under directed and random stimulus against a transaction-age model
module tb_bepu_bus_arbiter;
  logic clk = 1'b0;
  logic rst, r0, w0, r1, w1;
  logic [31:0] a0, d0, a1, d1;
  always #5 clk = ~clk;
  bepu_bus_arbiter_if if_rr ();
  bepu_bus_arbiter_if if_fp ();
  assign {if_rr.m0_req, if_rr.m0_w, if_rr.m0_addr, if_rr.m0_wdata} = {r0, w0, a0, d0};
  assign {if_rr.m1_req, if_rr.m1_w, if_rr.m1_addr, if_rr.m1_wdata} = {r1, w1, a1, d1};
  assign {if_fp.m0_req, if_fp.m0_w, if_fp.m0_addr, if_fp.m0_wdata} = {r0, w0, a0, d0};
  assign {if_fp.m1_req, if_fp.m1_w, if_fp.m1_addr, if_fp.m1_wdata} = {r1, w1, a1, d1};
  bepu_bus_arbiter #(.RR_ENABLE(1'b1)) u_rr (.clk(clk), .rst(rst), .b(if_rr.slave));
  bepu_bus_arbiter #(.RR_ENABLE(1'b0)) u_fp (.clk(clk), .rst(rst), .b(if_fp.slave));
  logic [31:0] mem [16];
  logic [31:0] sel_tab [16];
  always @(posedge clk) begin
    if_rr.bus_rdata <= mem[if_rr.bus_addr[5:2]];
    if_fp.bus_rdata <= mem[if_fp.bus_addr[5:2]];
  end
  logic [1:0][31:0] sel_o, addr_o, wd_o, rd0_o, rd1_o;
  logic [1:0] w_o, busy_o, ack0_o, ack1_o;
  assign sel_o  = {if_fp.bus_select, if_rr.bus_select};
  assign addr_o = {if_fp.bus_addr, if_rr.bus_addr};
  assign wd_o   = {if_fp.bus_wdata, if_rr.bus_wdata};
  assign rd0_o  = {if_fp.m0_rdata, if_rr.m0_rdata};
  assign rd1_o  = {if_fp.m1_rdata, if_rr.m1_rdata};
  assign w_o    = {if_fp.bus_w, if_rr.bus_w};
  assign busy_o = {if_fp.busy, if_rr.busy};
  assign ack0_o = {if_fp.m0_ack, if_rr.m0_ack};
  assign ack1_o = {if_fp.m1_ack, if_rr.m1_ack};
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Model: age of the current transaction since its grant edge (1 access, 2 resp, 3 ack, 0 none); index 0 = rr, 1 = fixed
  int age [2], last [2], mw [2];
  logic tw [2];
  logic [31:0] taddr [2], twd [2];
  logic [31:0] rdx [2][2];
  task automatic step_model(input int d);
    int g;
    if (rst) begin
      age[d] = 0; last[d] = 1; rdx[d][0] = 0; rdx[d][1] = 0;
    end else if (age[d] == 2) begin
      age[d] = 3;
      rdx[d][mw[d]] = (tw[d] || sel_tab[taddr[d][15:12]] == 0) ? 32'd0 : mem[taddr[d][5:2]];
    end else if (age[d] == 1) begin
      age[d] = 2;
    end else if (r0 || r1) begin
      g = (r0 && r1) ? (d == 0 ? 1 - last[d] : 0) : (r1 ? 1 : 0);
      mw[d] = g; last[d] = g; age[d] = 1;
      tw[d] = g ? w1 : w0; taddr[d] = g ? a1 : a0; twd[d] = g ? d1 : d0;
    end else begin
      age[d] = 0;
    end
  endtask
  task automatic check_all(input int d);
    string n;
    logic act;
    n = d ? "fp" : "rr";
    act = age[d] == 1 || age[d] == 2;
    chk({n, ".busy"}, 32'(busy_o[d]), 32'(act));
    chk({n, ".bus_w"}, 32'(w_o[d]), 32'(age[d] == 1 && tw[d]));
    chk({n, ".bus_select"}, sel_o[d], act ? sel_tab[taddr[d][15:12]] : 32'd0);
    chk({n, ".bus_addr"}, addr_o[d], act ? taddr[d] : 32'd0);
    if (age[d] != 2) chk({n, ".bus_wdata"}, wd_o[d], age[d] == 1 ? twd[d] : 32'd0);
    chk({n, ".m0_ack"}, 32'(ack0_o[d]), 32'(age[d] == 3 && mw[d] == 0));
    chk({n, ".m1_ack"}, 32'(ack1_o[d]), 32'(age[d] == 3 && mw[d] == 1));
    chk({n, ".m0_rdata"}, rd0_o[d], rdx[d][0]);
    chk({n, ".m1_rdata"}, rd1_o[d], rdx[d][1]);
  endtask
  task automatic cycle(input logic rs, q0, ww0, input logic [31:0] aa0, dd0,
                       input logic q1, ww1, input logic [31:0] aa1, dd1);
    @(negedge clk);
    rst = rs; r0 = q0; w0 = ww0; a0 = aa0; d0 = dd0; r1 = q1; w1 = ww1; a1 = aa1; d1 = dd1;
    step_model(0);
    step_model(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask
  task automatic idle(input logic rs);
    cycle(rs, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  int n_rr0, n_rr1, n_fp0, n_fp1;
  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[2] = 32'hDEADBEEF;
    foreach (sel_tab[i]) sel_tab[i] = 32'd0;
    sel_tab[0] = 32'h8000_0000; sel_tab[1] = 32'h1; sel_tab[2] = 32'h2; sel_tab[3] = 32'h4; sel_tab[4] = 32'h8;
    idle(1); idle(1);
    chk("rst_busy", 32'(if_rr.busy), 0);
    chk("rst_rdata", if_rr.m0_rdata, 0);
    idle(0);
    cycle(0, 1, 1, 32'h1000, 32'hA5, 0, 0, 0, 0);
    chk("wr_sel", if_rr.bus_select, 32'h1);
    chk("wr_w", 32'(if_rr.bus_w), 1);
    cycle(0, 1, 1, 32'h1000, 32'hA5, 0, 0, 0, 0);
    chk("wr_w_resp", 32'(if_rr.bus_w), 0);
    cycle(0, 1, 1, 32'h1000, 32'hA5, 0, 0, 0, 0);
    chk("wr_ack", 32'(if_rr.m0_ack), 1);
    chk("wr_rdata", if_rr.m0_rdata, 0);
    idle(0);
    cycle(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("rd_sel", if_rr.bus_select, 32'h8000_0000);
    cycle(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("rd_ack", 32'(if_rr.m0_ack), 1);
    chk("rd_data", if_rr.m0_rdata, 32'hDEADBEEF);
    idle(1);
    n_rr0 = 0; n_rr1 = 0; n_fp0 = 0; n_fp1 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 1, 32'h2000, 32'h11 + i, 1, 0, 32'h4, 0);
      n_rr0 += int'(if_rr.m0_ack); n_rr1 += int'(if_rr.m1_ack);
      n_fp0 += int'(if_fp.m0_ack); n_fp1 += int'(if_fp.m1_ack);
      if (i == 2) chk("rr_first_m0", 32'(if_rr.m0_ack), 1);
      if (i == 5) chk("rr_second_m1", 32'(if_rr.m1_ack), 1);
    end
    chk("rr_m0_acks", n_rr0, 2);
    chk("rr_m1_acks", n_rr1, 2);
    chk("fp_m0_acks", n_fp0, 4);
    chk("fp_m1_acks", n_fp1, 0);
    n_fp1 = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
      n_fp1 += int'(if_fp.m1_ack);
    end
    chk("fp_m1_after_drop", n_fp1, 1);
    idle(0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h7000, 0);
    chk("unm_sel", if_rr.bus_select, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h7000, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h7000, 0);
    chk("unm_ack", 32'(if_rr.m1_ack), 1);
    chk("unm_rdata", if_rr.m1_rdata, 0);
    idle(0);
    cycle(0, 1, 1, 32'h3000, 32'h77, 1, 1, 32'h1000, 32'h55);
    chk("abort_w_before", 32'(if_rr.bus_w), 1);
    cycle(1, 1, 1, 32'h3000, 32'h77, 1, 1, 32'h1000, 32'h55);
    chk("abort_w", 32'(if_rr.bus_w), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 32'h3000, 32'h77, 1, 1, 32'h1000, 32'h55);
    chk("abort_m0_ack", 32'(if_rr.m0_ack), 1);
    chk("abort_m1_ack", 32'(if_rr.m1_ack), 0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFFF_0FFC), $urandom,
            $urandom_range(0, 3) != 0, 1'($urandom),
            ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFFF_0FFC), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
